// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
// Holds the opcode map, FSM states and flag bit positions.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_SHL  = 4'b0100,
      OP_SHR  = 4'b0101,
      OP_ROL1 = 4'b0110,
      OP_ROR1 = 4'b0111,
      OP_AND  = 4'b1000,
      OP_OR   = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_NOR  = 4'b1011,
      OP_NAND = 4'b1100,
      OP_XNOR = 4'b1101,
      OP_GT   = 4'b1110,
      OP_EQ   = 4'b1111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int FLG_Z  = 0;
   localparam int FLG_C  = 1;
   localparam int FLG_V  = 2;
   localparam int FLG_DZ = 3;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative shift-add multiplier and restoring divider,
// one bit per cycle over WIDTH cycles (divider only with ALU_SEQ_DIV_EN).
// Ports: clk, rst (sync, active-high), start/is_div/a/b load an operation,
//   busy while iterating, done on the final step, res_lo = product low or
//   quotient, res_hi = product high (remainder for divide). res_* are the
//   values the engine registers on the current step, valid when done=1.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] mc;
   logic [WIDTH-1:0] hi_n;
   logic [WIDTH-1:0] lo_n;
   logic [WIDTH:0]   add;
   logic             load;

`ifdef ALU_SEQ_DIV_EN
   logic             div_q;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   trial;

   assign load = start;
`else
   // No divider: a divide request never starts the engine.
   assign load = start & ~is_div;
`endif

   always_comb begin
      // Multiply: {hi,lo} holds partial product and remaining multiplier.
      add  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
      hi_n = add[WIDTH:1];
      lo_n = {add[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      // Divide: hi is the partial remainder, lo shifts dividend out and
      // quotient bits in.
      shl   = {hi, lo[WIDTH-1]};
      trial = shl - {1'b0, mc};
      if (div_q) begin
         if (!trial[WIDTH]) begin
            hi_n = trial[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = shl[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   assign done   = busy && (cnt == '0);
   assign res_lo = lo_n;
   assign res_hi = hi_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         mc   <= '0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= 1'b0;
`endif
      end else if (load) begin
         busy <= 1'b1;
         cnt  <= CW'(WIDTH - 1);
         hi   <= '0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= is_div;
         lo    <= is_div ? a : b;
         mc    <= is_div ? b : a;
`else
         lo    <= b;
         mc    <= a;
`endif
      end else if (busy) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt - CW'(1);
         if (cnt == '0) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and flags,
// single-cycle ops plus iterative MUL/DIV. Macro ALU_SEQ_DIV_EN builds DIV.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, op;
//   out_valid/out_ready with result and flags {DZ, V, C, Z}.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

   state_e           state;
   state_e           state_nx;
   op_e              op_q;
   logic             accept;
   logic             go_iter;
   logic             is_div;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c;
   logic             sc_dz;
   logic [3:0]       sc_flg;
   logic             md_busy;
   logic             md_done;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;
   logic [3:0]       md_flg;

   // in_ready depends only on state and out_ready.
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign is_div    = (op == OP_DIV);

`ifdef ALU_SEQ_DIV_EN
   assign go_iter = (op == OP_MUL) || (is_div && (b != '0));
`else
   assign go_iter = (op == OP_MUL);
`endif

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      sc_res = '0;
      sc_c   = 1'b0;
      sc_dz  = 1'b0;
      unique case (op_e'(op))
         OP_ADD: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
         end
         OP_SUB: begin
            sc_res = diff[WIDTH-1:0];
            sc_c   = diff[WIDTH];
         end
         OP_MUL: sc_res = '0;
         OP_DIV: begin
            // Only reached here for b==0, or always when no divider.
`ifdef ALU_SEQ_DIV_EN
            sc_res = '1;
`else
            sc_res = '0;
`endif
            sc_dz  = 1'b1;
         end
         OP_SHL: sc_res = (b >= WVAL) ? '0 : (a << b[SHW-1:0]);
         OP_SHR: sc_res = (b >= WVAL) ? '0 : (a >> b[SHW-1:0]);
         OP_ROL1: sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
         OP_ROR1: sc_res = {a[0], a[WIDTH-1:1]};
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_NOR:  sc_res = ~(a | b);
         OP_NAND: sc_res = ~(a & b);
         OP_XNOR: sc_res = ~(a ^ b);
         OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      endcase
      sc_flg         = '0;
      sc_flg[FLG_Z]  = (sc_res == '0);
      sc_flg[FLG_C]  = sc_c;
      sc_flg[FLG_DZ] = sc_dz;
   end

   always_comb begin
      md_flg        = '0;
      md_flg[FLG_Z] = (md_lo == '0);
      md_flg[FLG_V] = (op_q == OP_MUL) && (md_hi != '0);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (in_valid) state_nx = go_iter ? BUSY : DONE;
         end
         BUSY: begin
            if (md_done)      state_nx = DONE;
            else if (!md_busy) state_nx = IDLE;
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid) state_nx = go_iter ? BUSY : DONE;
               else          state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= OP_ADD;
         result <= '0;
         flags  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q <= op_e'(op);
         end
         if (accept && !go_iter) begin
            result <= sc_res;
            flags  <= sc_flg;
         end else if ((state == BUSY) && md_done) begin
            result <= md_lo;
            flags  <= md_flg;
         end
      end
   end

   alu_seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_md (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && go_iter),
      .is_div (is_div),
      .a      (a),
      .b      (b),
      .busy   (md_busy),
      .done   (md_done),
      .res_lo (md_lo),
      .res_hi (md_hi)
   );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
// Expected values are hand-computed constants.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] op = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic [3:0] flags;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   // Issue one op from IDLE, wait for the result, then consume it.
   task automatic do_op(input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, output logic [7:0] r,
                        output logic [3:0] f, output int lat,
                        output bit rdy_busy);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'hFF; b = 8'h01; op = 4'h0;
      lat = 1; rdy_busy = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_busy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      r = result; f = flags;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result got %h want 00", result); end
      n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", flags); end
   endtask

   task automatic test_arith;
      logic [7:0] r; logic [3:0] f; int lat; bit rb;
      do_op(OP_ADD, 8'h27, 8'hB8, r, f, lat, rb);
      n_cmp++; if (r !== 8'hDF) begin n_bad++; $display("FAIL add_result got %h want df", r); end
      n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL add_flags got %b want 0000", f); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency got %0d want 1", lat); end
      do_op(OP_SUB, 8'h27, 8'hB8, r, f, lat, rb);
      n_cmp++; if (r !== 8'h6F) begin n_bad++; $display("FAIL sub_result got %h want 6f", r); end
      n_cmp++; if (f !== 4'b0010) begin n_bad++; $display("FAIL sub_flags got %b want 0010", f); end
      do_op(OP_ADD, 8'hFF, 8'h01, r, f, lat, rb);
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL add_wrap_result got %h want 00", r); end
      n_cmp++; if (f !== 4'b0011) begin n_bad++; $display("FAIL add_wrap_flags got %b want 0011", f); end
   endtask

   task automatic test_mul;
      logic [7:0] r; logic [3:0] f; int lat; bit rb;
      do_op(OP_MUL, 8'h27, 8'hB8, r, f, lat, rb);
      n_cmp++; if (r !== 8'h08) begin n_bad++; $display("FAIL mul_result got %h want 08", r); end
      n_cmp++; if (f !== 4'b0100) begin n_bad++; $display("FAIL mul_flags got %b want 0100", f); end
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL mul_latency got %0d want 9", lat); end
      n_cmp++; if (rb !== 1'b0) begin n_bad++; $display("FAIL mul_busy_ready got %b want 0", rb); end
      do_op(OP_MUL, 8'h0F, 8'h03, r, f, lat, rb);
      n_cmp++; if (r !== 8'h2D) begin n_bad++; $display("FAIL mul_small_result got %h want 2d", r); end
      n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL mul_small_flags got %b want 0000", f); end
   endtask

   task automatic test_div;
      logic [7:0] r; logic [3:0] f; int lat; bit rb;
      do_op(OP_DIV, 8'hB8, 8'h27, r, f, lat, rb);
`ifdef ALU_SEQ_DIV_EN
      n_cmp++; if (r !== 8'h04) begin n_bad++; $display("FAIL div_result got %h want 04", r); end
      n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL div_flags got %b want 0000", f); end
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL div_latency got %0d want 9", lat); end
`else
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL div_result got %h want 00", r); end
      n_cmp++; if (f !== 4'b1001) begin n_bad++; $display("FAIL div_flags got %b want 1001", f); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL div_latency got %0d want 1", lat); end
`endif
      do_op(OP_DIV, 8'h27, 8'h00, r, f, lat, rb);
`ifdef ALU_SEQ_DIV_EN
      n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL div0_result got %h want ff", r); end
      n_cmp++; if (f !== 4'b1000) begin n_bad++; $display("FAIL div0_flags got %b want 1000", f); end
`else
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL div0_result got %h want 00", r); end
      n_cmp++; if (f !== 4'b1001) begin n_bad++; $display("FAIL div0_flags got %b want 1001", f); end
`endif
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL div0_latency got %0d want 1", lat); end
   endtask

   task automatic test_single_cycle;
      logic [3:0] vo [17];
      logic [7:0] va [17];
      logic [7:0] vb [17];
      logic [7:0] vr [17];
      logic [3:0] vf [17];
      logic [7:0] r; logic [3:0] f; int lat; bit rb;
      vo = '{OP_SHL, OP_SHL, OP_SHL, OP_SHR, OP_SHR, OP_ROL1, OP_ROR1,
             OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR,
             OP_GT, OP_GT, OP_EQ, OP_EQ};
      va = '{8'h27, 8'h27, 8'h27, 8'hB8, 8'hB8, 8'h81, 8'h81,
             8'h27, 8'h27, 8'h27, 8'h27, 8'h27, 8'h27,
             8'h27, 8'hB8, 8'h5A, 8'h5A};
      vb = '{8'h09, 8'h08, 8'h07, 8'h03, 8'hFF, 8'h00, 8'h00,
             8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8,
             8'hB8, 8'h27, 8'h5A, 8'h5B};
      vr = '{8'h00, 8'h00, 8'h80, 8'h17, 8'h00, 8'h03, 8'hC0,
             8'h20, 8'hBF, 8'h9F, 8'h40, 8'hDF, 8'h60,
             8'h00, 8'h01, 8'h01, 8'h00};
      vf = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000,
             4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
             4'b0001, 4'b0000, 4'b0000, 4'b0001};
      for (int i = 0; i < 17; i++) begin
         do_op(vo[i], va[i], vb[i], r, f, lat, rb);
         n_cmp++;
         if (r !== vr[i] || f !== vf[i] || lat !== 1) begin
            n_bad++;
            $display("FAIL single_cycle[%0d] op=%h got %h/%b/%0d want %h/%b/1",
                     i, vo[i], r, f, lat, vr[i], vf[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      op = OP_ADD; a = 8'h27; b = 8'hB8; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'h11; b = 8'h22;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || result !== 8'hDF || flags !== 4'b0000 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold[%0d] got v=%b r=%h f=%b rdy=%b want v=1 r=df f=0000 rdy=0",
                     i, out_valid, result, flags, in_ready);
         end
         @(posedge clk); #1;
      end
      op = OP_XOR; a = 8'h27; b = 8'hB8; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL done_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 8'h9F) begin
         n_bad++;
         $display("FAIL overlap_xor got v=%b r=%h want v=1 r=9f", out_valid, result);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      logic [3:0] vo [4];
      logic [7:0] va [4];
      logic [7:0] vb [4];
      logic [7:0] vr [4];
      vo = '{OP_ADD, OP_SUB, OP_AND, OP_EQ};
      va = '{8'h27, 8'h27, 8'h27, 8'h5A};
      vb = '{8'hB8, 8'hB8, 8'hB8, 8'h5A};
      vr = '{8'hDF, 8'h6F, 8'h20, 8'h01};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op = vo[i]; a = va[i]; b = vb[i]; in_valid = 1'b1;
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || result !== vr[i]) begin
            n_bad++;
            $display("FAIL b2b[%0d] got v=%b r=%h want v=1 r=%h", i, out_valid, result, vr[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_busy;
      logic [7:0] r; logic [3:0] f; int lat; bit rb;
      op = OP_MUL; a = 8'h27; b = 8'hB8; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'b0000 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL abort got v=%b r=%h f=%b rdy=%b want v=0 r=00 f=0000 rdy=1",
                  out_valid, result, flags, in_ready);
      end
      repeat (10) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle got %b want 0", out_valid); end
      do_op(OP_ADD, 8'h27, 8'hB8, r, f, lat, rb);
      n_cmp++;
      if (r !== 8'hDF || f !== 4'b0000 || lat !== 1) begin
         n_bad++;
         $display("FAIL post_abort_add got %h/%b/%0d want df/0000/1", r, f, lat);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_mul();
      test_div();
      test_single_cycle();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
